// File: rtl/conv_unit.sv
// -----------------------------------------------------------------------------
// conv_unit: streaming 1-D convolution engine.
//
// Each accepted sample is shifted into a LEN-deep window. The kernel offered in
// the same handshake is latched, and the window/kernel dot product is built one
// multiply-accumulate per cycle. The result is then held until the consumer
// takes it.
//
// Optional build macro: CONV_CHECK_EN
//   When defined, adds the 'error' output and a combinational reference model
//   that flags any cycle where a presented result disagrees with the reference.
// -----------------------------------------------------------------------------

package Conv;
   parameter int LEN = 4;

   typedef logic [63:0]  data_t;
   typedef logic [127:0] result_t;

   typedef struct packed {
      data_t [LEN-1:0] data;
   } data_vector;
endpackage

module conv_unit
   import Conv::*;
(
   input  logic       clk,
   input  logic       rst,
   input  data_t      in_data,
   input  data_vector kernel,
   input  logic       in_valid,
   output logic       in_ready,
   output result_t    result,
   output logic       out_valid,
   input  logic       out_ready
`ifdef CONV_CHECK_EN
   ,
   output logic       error
`endif
);

   // Tap index width; at least one bit so a single-tap build still elaborates.
   localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Control state and registered outputs
   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [IDX_W-1:0] r_idx;
   result_t          r_acc;

   // Datapath storage: sliding window and kernel captured at accept
   data_t            r_win [LEN];
   data_vector       r_kern;

   // Datapath wires
   data_t            w_shift_in [LEN];
   data_t            w_tap;
   data_t            w_coef;
   result_t          w_prod;
   logic             w_accept;

   // An accept can only happen in IDLE, where in_ready is high.
   assign w_accept = (r_state == S_IDLE) && in_valid;

   // Next value of each window tap on accept: tap 0 takes the new sample, every
   // other tap takes its older neighbour.
   generate
      for (genvar gi = 0; gi < LEN; gi++) begin : g_shift
         if (gi == 0) begin : g_head
            assign w_shift_in[gi] = in_data;
         end else begin : g_body
            assign w_shift_in[gi] = r_win[gi-1];
         end
      end
   endgenerate

   // Window shift register, advanced only on an accepted transaction
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LEN; i++) begin
            r_win[i] <= '0;
         end
      end else if (w_accept) begin
         for (int i = 0; i < LEN; i++) begin
            r_win[i] <= w_shift_in[i];
         end
      end
   end

   // Kernel latch; later changes on the kernel inputs are ignored until the
   // next accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_kern <= '0;
      end else if (w_accept) begin
         r_kern <= kernel;
      end
   end

   // One tap per CALC cycle: select window tap and weight by the tap index,
   // then form the full-width unsigned 64x64 product.
   assign w_tap  = r_win[r_idx];
   assign w_coef = r_kern.data[r_idx];
   assign w_prod = result_t'(w_tap) * result_t'(w_coef);

   // Control FSM: accept -> LEN MAC cycles -> hold result until consumed
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_idx       <= '0;
         r_acc       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_state    <= S_CALC;
                  r_in_ready <= 1'b0;
                  r_idx      <= '0;
                  r_acc      <= '0;
               end
            end

            S_CALC: begin
               // Sum wraps naturally at 128 bits.
               r_acc <= r_acc + w_prod;
               if (r_idx == LAST_IDX) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_idx       <= '0;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end

            S_DONE: begin
               // in_ready returns in the cycle after the output handshake, so
               // no new accept can coincide with it.
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end

            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_idx       <= '0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_acc;

`ifdef CONV_CHECK_EN
   // Reference model: full dot product of the current window and latched
   // kernel, evaluated in parallel. The window and kernel cannot change while
   // a result is presented, so it stays comparable for the whole DONE phase.
   result_t w_ref_prod [LEN];
   result_t w_ref_sum;

   generate
      for (genvar gi = 0; gi < LEN; gi++) begin : g_ref
         assign w_ref_prod[gi] = result_t'(r_win[gi]) * result_t'(r_kern.data[gi]);
      end
   endgenerate

   // Wrapping sum of the reference products
   always_comb begin
      w_ref_sum = '0;
      for (int i = 0; i < LEN; i++) begin
         w_ref_sum = w_ref_sum + w_ref_prod[i];
      end
   end

   // Flag is decoded from registered state only; it is low whenever no result
   // is presented, including through reset.
   assign error = r_out_valid && (r_acc != w_ref_sum);
`endif

endmodule

// File: tb/tb_conv_unit.sv
// -----------------------------------------------------------------------------
// tb_conv_unit: directed self-checking bench for conv_unit.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------

module tb_conv_unit;
   import Conv::*;

   localparam data_t   MAXV   = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam result_t WRAP1  = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
   localparam result_t WRAP4  = 128'hFFFF_FFFF_FFFF_FFF8_0000_0000_0000_0004;

   logic       clk;
   logic       rst;
   data_t      in_data;
   data_vector kernel;
   logic       in_valid;
   logic       in_ready;
   result_t    result;
   logic       out_valid;
   logic       out_ready;
`ifdef CONV_CHECK_EN
   logic       error;
`endif

   int n_vec;
   int n_err;

   conv_unit dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .kernel    (kernel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .result    (result),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef CONV_CHECK_EN
      ,
      .error     (error)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something blocks forever
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input result_t got, input result_t exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic data_vector mk_k(input data_t a, input data_t b,
                                       input data_t c, input data_t d);
      data_vector v;
      v.data[0] = a;
      v.data[1] = b;
      v.data[2] = c;
      v.data[3] = d;
      return v;
   endfunction

   // Offer one transaction and return #1 after the accept edge.
   task automatic accept(input data_t s, input data_vector k);
      int n;
      n = 0;
      in_data  = s;
      kernel   = k;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) chk("accept_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count clock edges from the accept until out_valid is seen (bounded).
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Full transaction with out_ready held high.
   task automatic run_txn(input string tag, input data_t s, input data_vector k,
                          input result_t exp);
      int lat;
      accept(s, k);
      wait_valid(lat);
      chk({tag, "_lat"}, 128'(lat), 128'(LEN));
      chk({tag, "_res"}, result, exp);
      $display("txn %s: sample=%0h result=%0h latency=%0d", tag, s, result, lat);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 128'(out_valid), 128'(0));
      chk({tag, "_rdy"}, 128'(in_ready), 128'(1));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      int   lat;
      logic seen_valid;
      data_vector k1234;
      data_vector k1111;

      n_vec     = 0;
      n_err     = 0;
      k1234     = mk_k(1, 2, 3, 4);
      k1111     = mk_k(1, 1, 1, 1);
      rst       = 1'b0;
      in_data   = '0;
      kernel    = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;

      // Reset hold
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_result", result, 128'(0));
      $display("txn reset_hold: in_ready=%0b out_valid=%0b", in_ready, out_valid);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rel_in_ready", 128'(in_ready), 128'(1));

      // Window fill with kernel {1,2,3,4}
      run_txn("fill10", 10, k1234, 128'd10);
      run_txn("fill20", 20, k1234, 128'd40);
      run_txn("fill30", 30, k1234, 128'd100);
      run_txn("fill40", 40, k1234, 128'd200);
      run_txn("fill50", 50, k1234, 128'd300);

      // Backpressure: window becomes {60,50,40,30} -> 400
      out_ready = 1'b0;
      accept(60, k1234);
      wait_valid(lat);
      chk("bp_lat", 128'(lat), 128'(LEN));
      chk("bp_res", result, 128'd400);
      in_data  = 99;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_res", result, 128'd400);
         chk("bp_hold_rdy", 128'(in_ready), 128'(0));
         chk("bp_hold_ov", 128'(out_valid), 128'(1));
      end
      $display("txn backpressure: sample=60 result=%0h", result);
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_release_ov", 128'(out_valid), 128'(0));
      // 99 must not have entered: {70,60,50,40} . {0,1,1,1} = 150
      run_txn("bp_window", 70, mk_k(0, 1, 1, 1), 128'd150);

      // Kernel latch: {5,70,60,50} . {1,1,1,1} = 185, kernel zeroed during CALC
      accept(5, k1111);
      kernel = '0;
      wait_valid(lat);
      chk("klatch_lat", 128'(lat), 128'(LEN));
      chk("klatch_res", result, 128'd185);
      $display("txn kernel_latch: sample=5 result=%0h", result);
      @(posedge clk); #1;

      // Wrap-around from an empty window
      do_reset();
      run_txn("wrap1", MAXV, mk_k(MAXV, MAXV, MAXV, MAXV), WRAP1);
      run_txn("wrap2", MAXV, mk_k(MAXV, MAXV, MAXV, MAXV), WRAP1 + WRAP1);
      run_txn("wrap3", MAXV, mk_k(MAXV, MAXV, MAXV, MAXV), WRAP1 + WRAP1 + WRAP1);
      run_txn("wrap4", MAXV, mk_k(MAXV, MAXV, MAXV, MAXV), WRAP4);

      // Reset mid-CALC
      seen_valid = 1'b0;
      accept(3, k1234);
      repeat (2) begin
         @(posedge clk); #1;
         if (out_valid) seen_valid = 1'b1;
      end
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", 128'(in_ready), 128'(1));
      chk("midrst_out_valid", 128'(out_valid), 128'(0));
      chk("midrst_result", result, 128'(0));
      repeat (2) begin
         @(posedge clk); #1;
         if (out_valid) seen_valid = 1'b1;
      end
      rst = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid) seen_valid = 1'b1;
      end
      chk("midrst_no_valid", 128'(seen_valid), 128'(0));
      $display("txn reset_mid_calc: sample=3 discarded");
      run_txn("after_rst", 7, k1111, 128'd7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
